// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU, source-bus and OAM-write signals of the OAM DMA controller.
//   master (controller): in  cpu_sel, cpu_wr, cpu_addr[15:0], cpu_di[7:0], dma_data[7:0]
//                        out cpu_do[7:0], busy, dma_rd, dma_addr[15:0],
//                            oam_wr, oam_addr[7:0], oam_data[7:0], cpu_block
//   slave (system side): the same signals, opposite directions
interface oam_dma_if;
   logic        cpu_sel;
   logic        cpu_wr;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_di;
   logic [7:0]  cpu_do;
   logic        busy;
   logic        dma_rd;
   logic [15:0] dma_addr;
   logic [7:0]  dma_data;
   logic        oam_wr;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_data;
   logic        cpu_block;
   modport master (
      input  cpu_sel, cpu_wr, cpu_addr, cpu_di, dma_data,
      output cpu_do, busy, dma_rd, dma_addr, oam_wr, oam_addr, oam_data, cpu_block
   );
   modport slave (
      output cpu_sel, cpu_wr, cpu_addr, cpu_di, dma_data,
      input  cpu_do, busy, dma_rd, dma_addr, oam_wr, oam_addr, oam_data, cpu_block
   );
endinterface

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sequences the $FF46 OAM DMA, copying XFER_LEN bytes from page $XX00 into OAM.
//   clk      in  system clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      oam_dma_if.master: CPU write port/readback, source bus, OAM write port, cpu_block
//   OAM_DMA_CPU_BLOCK_EN defined: cpu_block flags CPU accesses outside $FF80-$FFFF/$FF46 while busy;
//   undefined: cpu_block tied low.
module oam_dma_ctrl #(
   parameter int XFER_LEN     = 160,
   parameter int CYC_PER_BYTE = 4,
   parameter int START_DELAY  = 4
) (
   input logic       clk,
   input logic       reset_n,
   oam_dma_if.master bus
);
   typedef enum logic [1:0] {IDLE, START, XFER} state_t;
   localparam logic [3:0] DLY     = 4'(START_DELAY);
   localparam logic [3:0] CYC_WR  = 4'(CYC_PER_BYTE - 2);
   localparam logic [3:0] CYC_END = 4'(CYC_PER_BYTE - 1);
   localparam logic [7:0] IDX_END = 8'(XFER_LEN - 1);
   state_t      r_state;
   logic [7:0]  r_page, r_src, r_idx, r_oam_addr;
   logic [3:0]  r_dly, r_cyc;
   logic        r_busy, r_rd, r_oam_wr;
   logic [15:0] r_addr;
   logic        w_wr;
   assign w_wr = bus.cpu_sel && bus.cpu_wr;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_state    <= IDLE;
         r_page     <= '0;
         r_src      <= '0;
         r_idx      <= '0;
         r_oam_addr <= '0;
         r_dly      <= '0;
         r_cyc      <= '0;
         r_busy     <= 1'b0;
         r_rd       <= 1'b0;
         r_oam_wr   <= 1'b0;
         r_addr     <= '0;
      end else if (w_wr) begin
         // every accepted write (re)starts from byte 0; echo RAM pages fold onto $C0-$DF
         r_state  <= START;
         r_page   <= bus.cpu_di;
         r_src    <= (bus.cpu_di >= 8'hE0) ? (bus.cpu_di & 8'hDF) : bus.cpu_di;
         r_dly    <= DLY;
         r_idx    <= '0;
         r_cyc    <= '0;
         r_busy   <= 1'b1;
         r_rd     <= 1'b0;
         r_oam_wr <= 1'b0;
         r_addr   <= '0;
      end else if (r_state == START) begin
         r_dly <= r_dly - 4'd1;
         if (r_dly == 4'd0) begin
            r_state <= XFER;
            r_rd    <= 1'b1;
            r_addr  <= {r_src, 8'h00};
         end
      end else if (r_state == XFER) begin
         r_cyc    <= r_cyc + 4'd1;
         r_oam_wr <= 1'b0;
         // raise the strobe one edge early so it occupies the slot's last clk
         if (r_cyc == CYC_WR) begin
            r_oam_wr   <= 1'b1;
            r_oam_addr <= r_idx;
         end
         if (r_cyc == CYC_END) begin
            r_cyc <= '0;
            if (r_idx == IDX_END) begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_rd    <= 1'b0;
               r_addr  <= '0;
            end else begin
               r_idx  <= r_idx + 8'd1;
               r_addr <= {r_src, r_idx + 8'd1};
            end
         end
      end
   assign bus.cpu_do   = r_page;
   assign bus.busy     = r_busy;
   assign bus.dma_rd   = r_rd;
   assign bus.dma_addr = r_addr;
   assign bus.oam_wr   = r_oam_wr;
   assign bus.oam_addr = r_oam_addr;
   // source data arrives one clk after the address, i.e. during the strobe clk itself
   assign bus.oam_data = r_oam_wr ? bus.dma_data : 8'h00;
`ifdef OAM_DMA_CPU_BLOCK_EN
   assign bus.cpu_block = r_busy && (bus.cpu_addr[15:7] != 9'h1FF) && !bus.cpu_sel;
`else
   assign bus.cpu_block = 1'b0;
`endif
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: checks a default instance and a CYC_PER_BYTE=2/START_DELAY=0 instance
// against a timeline model derived from the transfer rules.
module tb_oam_dma_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic sel = 1'b0, wr = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [7:0] di = 8'h00;
   int n_chk = 0, n_pass = 0;
   int act[2] = '{0, 0};
   int t[2] = '{0, 0};
   int dl[2] = '{4, 0};
   int cy[2] = '{4, 2};
   int src = 0, page = 0;

   always #5 clk = ~clk;

   oam_dma_if if0 ();
   oam_dma_if if1 ();
   assign if0.cpu_sel = sel;
   assign if0.cpu_wr = wr;
   assign if0.cpu_addr = addr;
   assign if0.cpu_di = di;
   assign if1.cpu_sel = sel;
   assign if1.cpu_wr = wr;
   assign if1.cpu_addr = addr;
   assign if1.cpu_di = di;

   // source memory with one clk read latency; content = low address byte ^ page
   always @(posedge clk) begin
      if0.dma_data <= if0.dma_addr[7:0] ^ if0.dma_addr[15:8];
      if1.dma_data <= if1.dma_addr[7:0] ^ if1.dma_addr[15:8];
   end

   oam_dma_ctrl u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
   oam_dma_ctrl #(.XFER_LEN(160), .CYC_PER_BYTE(2), .START_DELAY(0)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));

   task automatic chk(int k, string tag, logic [15:0] o, logic [15:0] e);
      n_chk++;
      assert (o === e) n_pass++;
      else $error("FAIL dut%0d %s observed=%0h expected=%0h", k, tag, o, e);
   endtask

   task automatic check_one(int k, logic b, logic rd, logic [15:0] a, logic w,
                            logic [7:0] oa, logic [7:0] od, logic [7:0] cdo, logic cb);
      bit eb, er, ew, eblk;
      int u, by;
      eb = act[k] != 0;
      er = eb && t[k] > dl[k];
      u = t[k] - dl[k] - 1;
      by = er ? u / cy[k] : 0;
      ew = er && (u % cy[k] == cy[k] - 1);
`ifdef OAM_DMA_CPU_BLOCK_EN
      eblk = eb && (addr[15:7] != 9'h1FF) && !sel;
`else
      eblk = 1'b0;
`endif
      chk(k, "busy", 16'(b), 16'(eb));
      chk(k, "dma_rd", 16'(rd), 16'(er));
      chk(k, "oam_wr", 16'(w), 16'(ew));
      chk(k, "cpu_do", 16'(cdo), 16'(page));
      chk(k, "cpu_block", 16'(cb), 16'(eblk));
      if (er) chk(k, "dma_addr", a, 16'(src * 256 + by));
      if (ew) begin
         chk(k, "oam_addr", 16'(oa), 16'(by));
         chk(k, "oam_data", 16'(od), 16'((by ^ src) & 255));
      end
   endtask

   task automatic check_all();
      check_one(0, if0.busy, if0.dma_rd, if0.dma_addr, if0.oam_wr, if0.oam_addr, if0.oam_data, if0.cpu_do, if0.cpu_block);
      check_one(1, if1.busy, if1.dma_rd, if1.dma_addr, if1.oam_wr, if1.oam_addr, if1.oam_data, if1.cpu_do, if1.cpu_block);
   endtask

   task automatic check_reset();
      chk(0, "rst_busy", 16'(if0.busy), 16'h0);
      chk(0, "rst_dma_rd", 16'(if0.dma_rd), 16'h0);
      chk(0, "rst_dma_addr", if0.dma_addr, 16'h0);
      chk(0, "rst_oam_wr", 16'(if0.oam_wr), 16'h0);
      chk(0, "rst_oam_addr", 16'(if0.oam_addr), 16'h0);
      chk(0, "rst_oam_data", 16'(if0.oam_data), 16'h0);
      chk(0, "rst_cpu_do", 16'(if0.cpu_do), 16'h0);
      chk(0, "rst_cpu_block", 16'(if0.cpu_block), 16'h0);
      chk(1, "rst_busy", 16'(if1.busy), 16'h0);
      chk(1, "rst_oam_wr", 16'(if1.oam_wr), 16'h0);
      chk(1, "rst_dma_rd", 16'(if1.dma_rd), 16'h0);
   endtask

   task automatic step();
      bit acc;
      @(posedge clk);
      acc = sel && wr;
      if (acc) begin
         page = int'(di);
         src = (di >= 8'hE0) ? int'(di & 8'hDF) : int'(di);
      end
      for (int k = 0; k < 2; k++)
         if (acc) begin
            act[k] = 1;
            t[k] = 0;
         end else if (act[k] != 0) begin
            t[k]++;
            if (t[k] >= dl[k] + 1 + 160 * cy[k]) act[k] = 0;
         end
      @(negedge clk);
      check_all();
   endtask

   task automatic run(int n);
      repeat (n) begin
         sel = ($urandom_range(0, 7) == 0);
         wr = 1'b0;
         addr = ($urandom_range(0, 1) == 1) ? 16'(16'hFF00 | $urandom_range(0, 255)) : 16'($urandom);
         step();
      end
   endtask

   task automatic write_page(logic [7:0] d, int hold);
      sel = 1'b1;
      wr = 1'b1;
      di = d;
      repeat (hold) step();
      sel = 1'b0;
      wr = 1'b0;
   endtask

   initial begin
      #1 check_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      run(5);
      write_page(8'hC1, 1);
      run(700);
      write_page(8'hFE, 1);
      run(700);
      write_page(8'h80, 1);
      run(45);
      write_page(8'hC0, 1);
      run(700);
      write_page(8'($urandom), 3);
      run(700);
      for (int i = 0; i < 15; i++) begin
         write_page(8'($urandom), int'($urandom_range(1, 2)));
         run(int'($urandom_range(1, 700)));
      end
      run(700);
      write_page(8'hE5, 1);
      run(200);
      #2 reset_n = 1'b0;
      #1 check_reset();
      @(negedge clk);
      reset_n = 1'b1;
      act = '{0, 0};
      page = 0;
      run(60);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sequences the OAM DMA transfer started by a CPU write to $FF46: copies 160 bytes from source page $XX00-$XX9F into sprite attribute memory (OAM) $FE00-$FE9F.
- Owns the shared source bus for the duration of the transfer: drives the dma_rd, dma_addr and dma_data path that steers cart, vram and iram, and drives the OAM write port.
- Sits beside the video block; the top level routes its bus outputs into the existing address/data muxes.

Parameters:
- XFER_LEN, 160, number of bytes per transfer (source offset 0 .. XFER_LEN-1).
- CYC_PER_BYTE, 4, clk cycles per byte slot; legal values 2 .. 15.
- START_DELAY, 4, clk cycles between the $FF46 write and the first byte slot; legal values 0 .. 15.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_sel  in  1  CPU address decodes to $FF46.
- cpu_wr  in  1  CPU write strobe, level.
- cpu_addr  in  16  current CPU address, used only for blocking.
- cpu_di  in  8  CPU write data.
- cpu_do  out  8  readback of the last page value written.
- busy  out  1  high from the accepted write until the last OAM write completes.
- dma_rd  out  1  source bus owned by DMA.
- dma_addr  out  16  source address.
- dma_data  in  8  source read data, valid 1 clk after dma_addr (spram latency).
- oam_wr  out  1  OAM write strobe, one clk per byte.
- oam_addr  out  8  OAM byte index, 0 .. 159.
- oam_data  out  8  OAM write data.
- cpu_block  out  1  CPU access must be ignored (see Optional Feature).

Behaviour:
- Reset (async, reset_n=0): state IDLE; cpu_do=8'h00; busy=0; dma_rd=0; dma_addr=16'h0000; oam_wr=0; oam_addr=0; oam_data=0; cpu_block=0; counters cleared.
- A write is accepted on each rising clk edge where cpu_sel && cpu_wr. A write strobe held for several clocks re-accepts on every clock, which keeps restarting START; the transfer begins after the strobe drops.
- Accepted write: latch page = cpu_di and cpu_do = cpu_di.
  - Effective source page src = (cpu_di >= 8'hE0) ? (cpu_di & 8'hDF) : cpu_di. This maps echo RAM $E0-$FF to $C0-$DF.
  - Enter START with delay counter = START_DELAY and byte index idx = 0.
- States:
  - IDLE: outputs inactive.
  - START: busy=1, dma_rd=0. Count down; at 0 go to XFER. With START_DELAY=0, go to XFER on the next clk.
  - XFER: busy=1, dma_rd=1, dma_addr = {src, idx}, held stable for the whole CYC_PER_BYTE-cycle slot. On the last clk of the slot:
    - oam_wr=1 for exactly one clk, with oam_addr=idx and oam_data=dma_data sampled that clk.
    - If idx == XFER_LEN-1, go to IDLE; otherwise idx <= idx+1.
  - Back in IDLE: busy, dma_rd and oam_wr all fall together on the clk after the final oam_wr.
- Total occupancy from the accepted write to busy falling = START_DELAY + XFER_LEN*CYC_PER_BYTE + 1 clks.
- Restart: an accepted write in START or XFER aborts the current transfer. No further oam_wr for the old page; the new page is latched and the block re-enters START with idx=0. busy stays high throughout (no gap).
- idx never exceeds XFER_LEN-1; dma_addr low byte never exceeds 8'h9F.
- The block does not decode source type; the top level steers dma_addr to cart, vram or iram.

Optional Feature:
- OAM_DMA_CPU_BLOCK_EN defined:
  - cpu_block = busy && !(cpu_addr[15:7] == 9'h1FF) && !cpu_sel, i.e. CPU access is allowed only to $FF80-$FFFF and $FF46 while busy.
  - The top level returns 8'hFF for blocked reads and suppresses blocked writes.
- Not defined: cpu_block is tied to 0 and the CPU keeps full bus access (legacy behaviour).

Test Plan:
- Write $C1 to $FF46, with source model returning the low address byte, defaults -> busy rises next clk; first oam_wr at clk 4+4 with oam_addr=0, data=$00; 160 oam_wr pulses total, the last with oam_addr=159, data=$9F; busy low at clk 645.
- Write $FE -> dma_addr runs $DE00..$DE9F; cpu_do reads $FE.
- Write $80; after 10 bytes write $C0 -> no oam_wr between the two writes' slot boundaries for the old page; the next transfer starts at idx 0 from $C000; busy never drops.
- Assert reset_n=0 mid-XFER (async, between clk edges) -> all outputs at reset values immediately; no oam_wr after release.
- OAM_DMA_CPU_BLOCK_EN defined, during XFER: cpu_addr=$C000 -> cpu_block=1; cpu_addr=$FF90 -> 0; in IDLE -> 0.
- CYC_PER_BYTE=2, START_DELAY=0 -> oam_wr every 2 clks; first pulse 2 clks after the write; busy duration 321 clks.
